imm_encoder: RTL and testbench

- Pipelined immediate encoder: the inverse of the core's immediate generator.
- Accepts a 32-bit immediate value, a format select and a base instruction word, and produces the instruction word with the immediate bit-scattered into the RISC-V I/B/U/J/S field positions.
- Flags immediates that the selected format cannot represent, and counts delivered errored words.
- Sits between the debug/test-program generator and instruction memory write port; valid/ready on both sides.

---
 rtl/imm_encoder_if.sv | 27 ++
 rtl/imm_encoder.sv | 128 ++++++++++++
 tb/tb_imm_encoder.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
// Valid/ready request and result channels of the immediate encoder,
// plus the error-counter clear/readback.
interface imm_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_imm;
  logic [2:0]       in_sel;
  logic [31:0]      in_base;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic             err_clr;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_imm, in_sel, in_base, out_ready, err_clr,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );

  modport slave (
    input  in_valid, in_imm, in_sel, in_base, out_ready, err_clr,
    output in_ready, out_valid, out_instr, out_err, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: scatters a 32-bit immediate into the RISC-V
// I/B/U/J/S fields of a base instruction and flags unrepresentable values.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  imm_encoder_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic signed [31:0] r_imm_p1;
  logic [2:0]         r_sel_p1;
  logic [31:0]        r_base_p1;
  logic               r_vld_p1;
  logic [31:0]        r_instr_p2;
  logic               r_err_p2;
  logic               r_vld_p2;
  logic [CNT_W-1:0]   r_err_cnt;

  logic               w_in_ready;
  logic               w_acc;
  logic               w_adv;
  logic               w_take;
  logic [31:0]        w_instr;
  logic               w_err;

  // True when v sign-extends from its low nbits bits.
  function automatic logic fits(input logic signed [31:0] v, input int nbits);
    logic signed [31:0] t;
    t = v >>> (nbits - 1);
    return (t == 32'sd0) || (t == -32'sd1);
  endfunction

  function automatic logic [31:0] encode(input logic signed [31:0] v,
                                         input logic [2:0] sel,
                                         input logic [31:0] base);
    logic [31:0] w;
    w = base;
    case (sel)
      3'd0: w[31:20] = v[11:0];
      3'd1: begin
        w[31]    = v[12];
        w[30:25] = v[10:5];
        w[11:8]  = v[4:1];
        w[7]     = v[11];
      end
      3'd2: w[31:12] = v[31:12];
      3'd3: begin
        w[31]    = v[20];
        w[30:21] = v[10:1];
        w[20]    = v[11];
        w[19:12] = v[19:12];
      end
      3'd4: begin
        w[31:25] = v[11:5];
        w[11:7]  = v[4:0];
      end
      default: w = base;
    endcase
    return w;
  endfunction

  function automatic logic imm_bad(input logic signed [31:0] v, input logic [2:0] sel);
    logic bad;
    case (sel)
      3'd0:    bad = !fits(v, 12);
      3'd1:    bad = v[0] || !fits(v, 13);
      3'd2:    bad = (v[11:0] != 12'd0);
      3'd3:    bad = v[0] || !fits(v, 21);
      3'd4:    bad = !fits(v, 12);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign w_in_ready = !rst && (!r_vld_p1 || !r_vld_p2 || bus.out_ready);
  assign w_acc      = bus.in_valid && w_in_ready;
  assign w_adv      = r_vld_p1 && (!r_vld_p2 || bus.out_ready);
  assign w_take     = r_vld_p2 && bus.out_ready;
  assign w_instr    = encode(r_imm_p1, r_sel_p1, r_base_p1);
  assign w_err      = imm_bad(r_imm_p1, r_sel_p1);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_p2;
  assign bus.out_instr = r_instr_p2;
  assign bus.out_err   = r_err_p2;
  assign bus.err_count = r_err_cnt;

  // Stage p1: capture request on accept
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_imm_p1  <= $signed(bus.in_imm);
      r_sel_p1  <= bus.in_sel;
      r_base_p1 <= bus.in_base;
    end
  end

  // Stage p2: encoded result, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_instr_p2 <= '0;
      r_err_p2   <= 1'b0;
    end else begin
      if (w_acc)      r_vld_p1 <= 1'b1;
      else if (w_adv) r_vld_p1 <= 1'b0;
      if (w_adv) begin
        r_vld_p2   <= 1'b1;
        r_instr_p2 <= w_instr;
        r_err_p2   <= w_err;
      end else if (bus.out_ready) begin
        r_vld_p2   <= 1'b0;
      end
    end
  end

  // Clear has priority over a coincident errored handshake
  always_ff @(posedge clk) begin
    if (rst || bus.err_clr) begin
      r_err_cnt <= '0;
    end else if (w_take && r_err_p2 && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed formats, back-pressure,
// random streaming, saturating error counter and mid-flight reset.
module tb_imm_encoder;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_encoder_if #(.CNT_W(CNT_W)) bus();
  imm_encoder #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int delivered = 0;
  logic [32:0] sb[$];
  logic [32:0] mon_exp;

  function automatic logic [32:0] model(input logic [31:0] imm, input logic [2:0] sel,
                                        input logic [31:0] b);
    logic [31:0] ins;
    logic bad;
    case (sel)
      3'd0: begin ins = {imm[11:0], b[19:0]};
        bad = !(&imm[31:11] || ~|imm[31:11]); end
      3'd1: begin ins = {imm[12], imm[10:5], b[24:12], imm[4:1], imm[11], b[6:0]};
        bad = imm[0] || !(&imm[31:12] || ~|imm[31:12]); end
      3'd2: begin ins = {imm[31:12], b[11:0]}; bad = |imm[11:0]; end
      3'd3: begin ins = {imm[20], imm[10:1], imm[11], imm[19:12], b[11:0]};
        bad = imm[0] || !(&imm[31:20] || ~|imm[31:20]); end
      3'd4: begin ins = {imm[11:5], b[24:12], imm[4:0], b[6:0]};
        bad = !(&imm[31:11] || ~|imm[31:11]); end
      default: begin ins = b; bad = 1'b1; end
    endcase
    return {ins, bad};
  endfunction

  function automatic logic [31:0] legal_imm(input logic [2:0] sel, input logic [31:0] r);
    case (sel)
      3'd0, 3'd4: return {{20{r[11]}}, r[11:0]};
      3'd1:       return {{19{r[12]}}, r[12:1], 1'b0};
      3'd2:       return {r[31:12], 12'h000};
      3'd3:       return {{11{r[20]}}, r[20:1], 1'b0};
      default:    return r;
    endcase
  endfunction

  // Output-side scoreboard: every completed handshake pops one expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      delivered++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got instr=%h err=%b, required no output",
                 bus.out_instr, bus.out_err);
      end else begin
        mon_exp = sb.pop_front();
        if ({bus.out_instr, bus.out_err} !== mon_exp) begin
          failures++;
          $display("FAIL sb_data got instr=%h err=%b required instr=%h err=%b",
                   bus.out_instr, bus.out_err, mon_exp[32:1], mon_exp[0]);
        end
      end
    end
  end

  task automatic send(input logic [31:0] imm, input logic [2:0] sel,
                      input logic [31:0] base, input logic [32:0] exp);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_sel   = sel;
    bus.in_base  = base;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got in_ready=%b required 1", bus.in_ready);
    end else begin
      sb.push_back(exp);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got rdy/vld/err=%b%b%b required 000",
               bus.in_ready, bus.out_valid, bus.out_err);
    end
    checks++;
    if (bus.out_instr !== 32'h0 || bus.err_count !== 4'h0) begin
      failures++;
      $display("FAIL reset_data got instr=%h cnt=%0d required 0 0", bus.out_instr, bus.err_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    bus.out_ready = 1'b1;
    send(32'hFFFF_FFFF, 3'd0, 32'h0000_0013, {32'hFFF0_0013, 1'b0});
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early got out_valid=%b required 0", bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF0_0013) begin
      failures++;
      $display("FAIL latency_2cyc got vld=%b instr=%h required 1 fff00013",
               bus.out_valid, bus.out_instr);
    end
    wait_drain();
  endtask

  task automatic test_directed();
    bus.out_ready = 1'b1;
    send(32'h0000_0800, 3'd1, 32'h0000_0063, {32'h0000_00E3, 1'b0});
    send(32'h0000_0801, 3'd1, 32'h0000_0063, {32'h0000_00E3, 1'b1});
    send(32'h1234_5000, 3'd2, 32'h0000_00B7, {32'h1234_50B7, 1'b0});
    send(32'h1234_5001, 3'd2, 32'h0000_00B7, {32'h1234_50B7, 1'b1});
    send(32'hFFFF_FFFE, 3'd3, 32'h0000_006F, {32'hFFFF_F06F, 1'b0});
    send(32'h0010_0000, 3'd3, 32'h0000_006F, {32'h8000_006F, 1'b1});
    send(32'h0000_0800, 3'd4, 32'h0000_0023, {32'h8000_0023, 1'b1});
    send(32'hFFFF_F800, 3'd0, 32'h0000_0013, {32'h8000_0013, 1'b0});
    send(32'h0000_0800, 3'd0, 32'h0000_0013, {32'h8000_0013, 1'b1});
    send(32'h1234_5678, 3'd6, 32'hDEAD_BEEF, {32'hDEAD_BEEF, 1'b1});
    send(32'h0000_0005, 3'd7, 32'h0000_0013, {32'h0000_0013, 1'b1});
    wait_drain();
    checks++;
    if (bus.err_count !== 4'd7) begin
      failures++;
      $display("FAIL directed_errcnt got %0d required 7", bus.err_count);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] wi[3];
    logic [2:0]  ws[3];
    logic [31:0] wb[3];
    logic [32:0] e[3];
    int idx = 0;
    logic took;
    wi = '{32'h0000_0123, 32'hABCD_E000, 32'hFFFF_FFF0};
    ws = '{3'd0, 3'd2, 3'd4};
    wb = '{32'h0000_0013, 32'h0000_0037, 32'h0000_0023};
    for (int k = 0; k < 3; k++) e[k] = model(wi[k], ws[k], wb[k]);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_imm = wi[0]; bus.in_sel = ws[0]; bus.in_base = wb[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      took = 1'b0;
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (bus.out_instr !== e[0][32:1]) begin
          failures++;
          $display("FAIL bp_hold got instr=%h required %h", bus.out_instr, e[0][32:1]);
        end
      end
      if (bus.in_ready === 1'b1 && idx < 3) begin
        sb.push_back(e[idx]);
        took = 1'b1;
      end
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 3) begin
          bus.in_imm = wi[idx]; bus.in_sel = ws[idx]; bus.in_base = wb[idx];
        end
      end
    end
    checks++;
    if (idx != 2 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_full got accepted=%0d in_ready=%b out_valid=%b required 2 0 1",
               idx, bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_instr !== e[0][32:1] || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_a got instr=%h in_ready=%b required %h 1",
               bus.out_instr, bus.in_ready, e[0][32:1]);
    end
    if (bus.in_ready === 1'b1) sb.push_back(e[2]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== e[1][32:1]) begin
      failures++;
      $display("FAIL bp_release_b got vld=%b instr=%h required 1 %h",
               bus.out_valid, bus.out_instr, e[1][32:1]);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== e[2][32:1]) begin
      failures++;
      $display("FAIL bp_release_c got vld=%b instr=%h required 1 %h",
               bus.out_valid, bus.out_instr, e[2][32:1]);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_stream();
    int d0;
    logic [2:0]  s;
    logic [31:0] imm;
    logic [31:0] b;
    bus.out_ready = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 100; i++) begin
      s   = 3'($urandom_range(0, 4));
      imm = legal_imm(s, $urandom);
      b   = $urandom;
      send(imm, s, b, model(imm, s, b));
    end
    @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (delivered - d0 != 100 || sb.size() != 0) begin
      failures++;
      $display("FAIL stream_rate got delivered=%0d pending=%0d required 100 0",
               delivered - d0, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_err_counter();
    bus.out_ready = 1'b1;
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    checks++;
    if (bus.err_count !== 4'd0) begin
      failures++;
      $display("FAIL cnt_clear got %0d required 0", bus.err_count);
    end
    for (int i = 0; i < 20; i++)
      send(32'(i), 3'd6, 32'h0000_1000 + 32'(i), {32'h0000_1000 + 32'(i), 1'b1});
    wait_drain();
    checks++;
    if (bus.err_count !== 4'd15) begin
      failures++;
      $display("FAIL cnt_saturate got %0d required 15", bus.err_count);
    end
    bus.out_ready = 1'b0;
    send(32'h0, 3'd5, 32'h0000_1234, {32'h0000_1234, 1'b1});
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    checks++;
    if (bus.err_count !== 4'd0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL cnt_clr_wins got cnt=%0d vld=%b required 0 0", bus.err_count, bus.out_valid);
    end
    send(32'h0000_0801, 3'd1, 32'h0000_0063, {32'h0000_00E3, 1'b1});
    wait_drain();
    checks++;
    if (bus.err_count !== 4'd1) begin
      failures++;
      $display("FAIL cnt_after_clr got %0d required 1", bus.err_count);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send(32'h0, 3'd7, 32'h0000_00AA, {32'h0000_00AA, 1'b1});
    send(32'h0, 3'd7, 32'h0000_00BB, {32'h0000_00BB, 1'b1});
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel = 3'd7;
    sb.delete();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_ready got in_ready=%b required 0", bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.err_count !== 4'd0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_flush got vld=%b cnt=%0d rdy=%b required 0 0 0",
               bus.out_valid, bus.err_count, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.err_count !== 4'd0) begin
        failures++;
        $display("FAIL rstmid_after got vld=%b rdy=%b cnt=%0d required 0 1 0",
                 bus.out_valid, bus.in_ready, bus.err_count);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_imm = '0;
    bus.in_sel = '0;
    bus.in_base = '0;
    bus.out_ready = 1'b0;
    bus.err_clr = 1'b0;
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_stream();
    test_err_counter();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
